regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
Round-robin arbiter that shares the register file's single write port between N_REQ requesters (ALU result, load unit, immediate loader).
- Each requester presents a request, a destination address and write data.
- The arbiter picks one requester per cycle and drives a registered write (enable/address/data) into the register file.
- It returns a one-cycle ack to the winner.
- Sits between the execution units and the register file write port.

Parameters:
DATA_WIDTH, 4, width of register data.
ADDR_WIDTH, 2, width of register address.
N_REQ, 3, number of requesters (2..8).
ID_WIDTH, 2, width of grant_id; must be >= clog2(N_REQ), minimum 1.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
req  input  N_REQ  request per requester; held high until acked.
req_addr  input  N_REQ*ADDR_WIDTH  packed destination addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
req_data  input  N_REQ*DATA_WIDTH  packed write data; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
stall  input  1  when high, no new grant is issued.
ack  output  N_REQ  one-hot, one-cycle pulse to the served requester.
rf_wr_en  output  1  write enable to the register file.
rf_wr_addr  output  ADDR_WIDTH  write address to the register file.
rf_wr_data  output  DATA_WIDTH  write data to the register file.
grant_id  output  ID_WIDTH  index of the current winner; valid while rf_wr_en=1.
busy  output  1  registered: at least one req was pending last cycle.

Behaviour:
- Reset (rst=1 at rising edge): ack=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, busy=0, round-robin pointer ptr=0.
  - Reset overrides everything, including a grant in flight.
  - A write presented in the reset cycle is dropped; its requester keeps req high and is re-served after reset.
- Eligibility, combinational: elig[i] = req[i] & ~ack[i].
  - The requester acked this cycle is masked, which prevents a double grant while its req is still high.
- Selection:
  - Scan starts at index ptr and runs ascending, modulo N_REQ.
  - The first eligible index wins.
  - Scan is purely combinational from ptr and elig.
- Registered outputs, on the edge after selection (latency req -> rf_wr_en = 1 cycle):
  - If stall=0 and any elig: rf_wr_en=1, rf_wr_addr/rf_wr_data = winner's slices, ack = onehot(winner), grant_id = winner, ptr = (winner+1) mod N_REQ.
  - Otherwise: rf_wr_en=0, ack=0, ptr unchanged, addr/data/grant_id hold their previous values.
- Write timing: the register file commits on the edge ending the rf_wr_en cycle. The requester sees ack on that same edge and may drop req or present a new request in the following cycle.
- Throughput: one write per cycle back-to-back. A single requester alone gets at most one write every 2 cycles because of ack masking.
- Fairness: with all requesters continuously requesting, grants rotate strictly 0,1,..,N_REQ-1,0.
  - No requester waits more than N_REQ grant cycles (excluding stall cycles).
- Wrap-around: ptr = N_REQ-1 followed by a grant moves ptr to 0.
- Same-address requests from several requesters are not merged. Each is written in grant order; last grant wins the register contents.
- stall asserted while req is pending:
  - No grant; pending requests wait.
  - A grant already registered in the current cycle completes normally.
- busy: registered |req, 1-cycle lag, cleared by reset.
- Requesters must hold addr/data stable while req=1. The arbiter samples them only in the selection cycle.

Decomposition:
- Shared package (microcore_pkg): DATA_WIDTH=4 and ADDR_WIDTH=2 constants, and a clog2-based ID width helper, all shared with the register file.
- Sub-module rr_priority_picker: combinational; inputs elig and ptr; outputs winner index and a valid flag. Reusable for a future read-port arbiter.
- The top block holds ptr, the output registers and the packed-slice muxing.

Test Plan:
1. Reset with req=3'b111 held -> ack=0, rf_wr_en=0, outputs 0 during reset; first edge after reset release gives grant_id=0 (ptr=0).
2. req[1]=1, addr=2, data=4'hA at cycle t -> cycle t+1: rf_wr_en=1, rf_wr_addr=2, rf_wr_data=4'hA, ack=3'b010, grant_id=1; req dropped at t+2 -> rf_wr_en=0; register 2 reads 4'hA afterwards.
3. All three requesting continuously, each re-raising with new data after its ack -> rf_wr_en high every cycle, grant_id sequence 0,1,2,0,1,2, never the same id in consecutive cycles.
4. Masking: cycle t, ack[0]=1 while req[0] and req[2] are still high and ptr=1 -> cycle t+1 grant_id=2, ack=3'b100, ptr=0.
5. stall=1 for 3 cycles with req[0]=1 -> rf_wr_en=0 and ack=0 throughout; stall drops at cycle t -> rf_wr_en=1 and ack[0]=1 at t+1.
6. rst pulsed in a cycle where ack[2]=1 with req[0] and req[2] held high -> next cycle all outputs 0 and ptr=0; first grant after reset goes to 0, then to 2.

Source files
------------

// File: rtl/microcore_pkg.sv
// rtl/microcore_pkg.sv - register file widths and ID width helper shared across the core
package microcore_pkg;

    localparam int RF_DATA_WIDTH = 4;
    localparam int RF_ADDR_WIDTH = 2;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick of the first eligible index from ptr
module rr_priority_picker #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           valid
);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest eligible index is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (elig[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter sharing the register file write port
module regfile_wr_arbiter
    import microcore_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int N_REQ      = 3,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        stall,
    output logic [N_REQ-1:0]            ack,
    output logic                        rf_wr_en,
    output logic [ADDR_WIDTH-1:0]       rf_wr_addr,
    output logic [DATA_WIDTH-1:0]       rf_wr_data,
    output logic [ID_WIDTH-1:0]         grant_id,
    output logic                        busy
);

    logic [N_REQ-1:0]    elig;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] winner;
    logic                win_valid;

    // A requester acked this cycle still has req high; mask it to avoid a double grant.
    assign elig = req & ~ack;

    rr_priority_picker #(
        .N   (N_REQ),
        .IDW (ID_WIDTH)
    ) u_picker (
        .elig   (elig),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ack        <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            ptr        <= '0;
        end else begin
            busy <= |req;
            if (!stall && win_valid) begin
                rf_wr_en   <= 1'b1;
                rf_wr_addr <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                rf_wr_data <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                ack        <= N_REQ'(1) << winner;
                grant_id   <= winner;
                ptr        <= (int'(winner) == N_REQ - 1) ? '0 : winner + ID_WIDTH'(1);
            end else begin
                rf_wr_en <= 1'b0;
                ack      <= '0;
            end
        end
    end

endmodule
